loc_scan_ctrl: RTL and testbench

- Launch-on-capture (LOC) scan test sequencer for a full-scan circuit under test (CUT) in the transition-delay-fault flow.
- Accepts one pattern per handshake and drives the CUT's scan-enable, scan-in, clock-enable and primary inputs through shift, launch and capture.
- Unloads the captured response and compares it against expected values, reporting pass/fail per pattern.
- Overlaps each pattern's unload with the next pattern's load.

---
 rtl/tdf_pkg.sv | 27 ++
 rtl/loc_shift_unit.sv | 105 ++++++++++
 rtl/loc_scan_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_loc_scan_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdf_pkg.sv
// -----------------------------------------------------------------------------
// tdf_pkg
// Definitions shared by the launch-on-capture scan sequencer:
//   - state_e    : sequencer states
//   - GAP_CYCLES : dead cycles between the last shift and the launch edge. This
//                  gives scan-enable time to settle.
//   - cnt_width  : width of a counter that must hold values 0..n
// The pattern record depends on the instance widths, so loc_scan_ctrl
// declares it next to its parameters.
// -----------------------------------------------------------------------------
package tdf_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        GAP,
        LAUNCH,
        CAPTURE
    } state_e;

    localparam int unsigned GAP_CYCLES = 1;

    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/loc_shift_unit.sv
// -----------------------------------------------------------------------------
// loc_shift_unit
// Datapath for the scan chain side of the sequencer.
//   - Holds the load vector and presents one bit per shift cycle on si_o.
//     Bit 0 leaves first.
//   - Holds the expected unload and compares the scan-out bit of each unload
//     cycle against it. Any mismatch sets a sticky fail flag.
//   - Builds the captured unload word: bit i is scan-out in unload cycle i.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   load_i      pattern accepted this cycle; latch scan_i
//   scan_i      scan load vector
//   shift_i     SHIFT cycle that carries a load
//   unload_i    SHIFT cycle that carries an unload
//   cnt_i       shift cycle index 0..CHAIN_LEN-1
//   arm_i       CAPTURE cycle; latch exp_so_i and clear the sticky fail
//   exp_so_i    expected unload for the pattern being captured
//   so_i        scan-out from the CUT
//   si_o        scan-in bit to the CUT
//   fail_o      sticky fail, including the mismatch of the current cycle
//   res_so_o    captured unload word
// -----------------------------------------------------------------------------
module loc_shift_unit
    import tdf_pkg::*;
#(
    parameter int CHAIN_LEN = 3,
    parameter int CNT_W     = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_i,
    input  logic [CHAIN_LEN-1:0] scan_i,
    input  logic                 shift_i,
    input  logic                 unload_i,
    input  logic [CNT_W-1:0]     cnt_i,
    input  logic                 arm_i,
    input  logic [CHAIN_LEN-1:0] exp_so_i,
    input  logic                 so_i,
    output logic                 si_o,
    output logic                 fail_o,
    output logic [CHAIN_LEN-1:0] res_so_o
);

    logic [CHAIN_LEN-1:0] load_q, load_d;
    logic [CHAIN_LEN-1:0] exp_q, exp_d;
    logic [CHAIN_LEN-1:0] res_q, res_d;
    logic                 fail_q, fail_d;
    logic                 exp_bit;
    logic                 mismatch;

    always_comb begin
        // NOTE: every combinational output gets a default first. Any path that
        // leaves a variable unassigned would otherwise infer a latch.
        load_d  = load_q;
        exp_d   = exp_q;
        res_d   = res_q;
        exp_bit = 1'b0;

        if (load_i) begin
            load_d = scan_i;
        end else if (shift_i) begin
            load_d = load_q >> 1;
        end

        if (arm_i) begin
            exp_d = exp_so_i;
        end

        for (int i = 0; i < CHAIN_LEN; i++) begin
            if (cnt_i == CNT_W'(i)) begin
                exp_bit = exp_q[i];
                if (unload_i) begin
                    res_d[i] = so_i;
                end
            end
        end

        mismatch = unload_i & (so_i != exp_bit);
        // The last unload bit is folded in here, so the registered result sees
        // it in the same cycle that it is sampled.
        fail_o   = fail_q | mismatch;
        fail_d   = arm_i ? 1'b0 : fail_o;
    end

    assign si_o     = shift_i & load_q[0];
    assign res_so_o = res_q;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: all datapath registers are reset. This keeps the result and
        // scan-in outputs at known values immediately after reset.
        if (!rst_n) begin
            load_q <= '0;
            exp_q  <= '0;
            res_q  <= '0;
            fail_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment only.
            load_q <= load_d;
            exp_q  <= exp_d;
            res_q  <= res_d;
            fail_q <= fail_d;
        end
    end

endmodule

// File: rtl/loc_scan_ctrl.sv
// -----------------------------------------------------------------------------
// loc_scan_ctrl
// Launch-on-capture scan test sequencer for transition-delay testing of a
// single-chain full-scan CUT.
//
// Sequence for each pattern: SHIFT (CHAIN_LEN) -> GAP -> LAUNCH -> CAPTURE.
// The unload of one pattern runs in the same SHIFT window as the load of the
// next pattern. When no next pattern is offered in CAPTURE, an unload-only
// SHIFT runs and the sequencer then returns to IDLE.
//
// Ports:
//   CLK, RSTN    clock, asynchronous active-low reset
//   pat_*        pattern handshake and fields. Fields are latched on accept.
//   cut_se/ce    scan enable and flop clock enable (state decodes)
//   cut_si       scan-in bit
//   cut_pi       CUT primary inputs: v1 through launch, v2 in capture
//   cut_so/po    CUT scan-out and primary outputs
//   res_valid    one-cycle result strobe; res_fail and res_so are valid with it
//   busy         sequencer is not IDLE
// -----------------------------------------------------------------------------
module loc_scan_ctrl
    import tdf_pkg::*;
#(
    parameter int CHAIN_LEN = 3,
    parameter int NUM_PI    = 4,
    parameter int NUM_PO    = 1
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    input  logic                 pat_valid,
    output logic                 pat_ready,
    input  logic [CHAIN_LEN-1:0] pat_scan,
    input  logic [NUM_PI-1:0]    pat_v1,
    input  logic [NUM_PI-1:0]    pat_v2,
    input  logic [CHAIN_LEN-1:0] pat_exp_so,
    input  logic [NUM_PO-1:0]    pat_exp_po,
    output logic                 cut_se,
    output logic                 cut_ce,
    output logic                 cut_si,
    output logic [NUM_PI-1:0]    cut_pi,
    input  logic                 cut_so,
    input  logic [NUM_PO-1:0]    cut_po,
    output logic                 res_valid,
    output logic                 res_fail,
    output logic [CHAIN_LEN-1:0] res_so,
    output logic                 busy
);

    localparam int CNT_W = cnt_width(CHAIN_LEN);

    typedef struct packed {
        logic [CHAIN_LEN-1:0] scan;
        logic [NUM_PI-1:0]    v1;
        logic [NUM_PI-1:0]    v2;
        logic [CHAIN_LEN-1:0] exp_so;
        logic [NUM_PO-1:0]    exp_po;
    } pattern_t;

    // Fields kept after acceptance. The scan vector goes directly into the
    // shift unit, so it is not held here.
    typedef struct packed {
        logic [NUM_PI-1:0]    v1;
        logic [NUM_PI-1:0]    v2;
        logic [CHAIN_LEN-1:0] exp_so;
        logic [NUM_PO-1:0]    exp_po;
    } held_t;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_act_q, load_act_d;
    logic             unload_act_q, unload_act_d;
    logic             po_fail_q, po_fail_d;
    logic             res_valid_q, res_valid_d;
    logic             res_fail_q, res_fail_d;
    held_t            held_q, held_d;

    pattern_t         pat_in;
    logic             accept;
    logic             so_fail;
    logic             shift_ld;
    logic             shift_ul;
    logic             arm;

    assign pat_in = '{scan: pat_scan, v1: pat_v1, v2: pat_v2,
                      exp_so: pat_exp_so, exp_po: pat_exp_po};

    assign pat_ready = (state_q == IDLE) || (state_q == CAPTURE);
    assign accept    = pat_valid & pat_ready;

    assign shift_ld  = (state_q == SHIFT) & load_act_q;
    assign shift_ul  = (state_q == SHIFT) & unload_act_q;
    assign arm       = (state_q == CAPTURE);

    loc_shift_unit #(
        .CHAIN_LEN (CHAIN_LEN),
        .CNT_W     (CNT_W)
    ) u_shift (
        .clk      (CLK),
        .rst_n    (RSTN),
        .load_i   (accept),
        .scan_i   (pat_in.scan),
        .shift_i  (shift_ld),
        .unload_i (shift_ul),
        .cnt_i    (cnt_q),
        .arm_i    (arm),
        .exp_so_i (held_q.exp_so),
        .so_i     (cut_so),
        .si_o     (cut_si),
        .fail_o   (so_fail),
        .res_so_o (res_so)
    );

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        load_act_d   = load_act_q;
        unload_act_d = unload_act_q;
        po_fail_d    = po_fail_q;
        res_valid_d  = 1'b0;
        res_fail_d   = res_fail_q;
        held_d       = held_q;

        if (accept) begin
            held_d = '{v1: pat_in.v1, v2: pat_in.v2,
                       exp_so: pat_in.exp_so, exp_po: pat_in.exp_po};
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d      = SHIFT;
                    cnt_d        = '0;
                    load_act_d   = 1'b1;
                    unload_act_d = 1'b0;
                end
            end

            SHIFT: begin
                if (cnt_q == CNT_W'(CHAIN_LEN - 1)) begin
                    cnt_d = '0;
                    if (unload_act_q) begin
                        res_valid_d = 1'b1;
                        res_fail_d  = po_fail_q | so_fail;
                    end
                    if (load_act_q) begin
                        state_d = GAP;
                    end else begin
                        state_d      = IDLE;
                        unload_act_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            GAP: begin
                if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                    state_d = LAUNCH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            LAUNCH: begin
                state_d = CAPTURE;
            end

            CAPTURE: begin
                // The PO check uses the pattern that is finishing. held_q may
                // be overwritten by a newly accepted pattern on this same edge.
                po_fail_d    = (cut_po != held_q.exp_po);
                state_d      = SHIFT;
                cnt_d        = '0;
                load_act_d   = accept;
                unload_act_d = 1'b1;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            load_act_q   <= 1'b0;
            unload_act_q <= 1'b0;
            po_fail_q    <= 1'b0;
            res_valid_q  <= 1'b0;
            res_fail_q   <= 1'b0;
            held_q       <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            load_act_q   <= load_act_d;
            unload_act_q <= unload_act_d;
            po_fail_q    <= po_fail_d;
            res_valid_q  <= res_valid_d;
            res_fail_q   <= res_fail_d;
            held_q       <= held_d;
        end
    end

    // CUT controls are pure decodes of registered state
    assign cut_se = (state_q == SHIFT);
    assign cut_ce = (state_q == SHIFT) || (state_q == LAUNCH) || (state_q == CAPTURE);

    always_comb begin
        case (state_q)
            IDLE:    cut_pi = '0;
            CAPTURE: cut_pi = held_q.v2;
            default: cut_pi = held_q.v1;
        endcase
    end

    assign res_valid = res_valid_q;
    assign res_fail  = res_fail_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_loc_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_loc_scan_ctrl
// Directed bench for loc_scan_ctrl (CHAIN_LEN=3, NUM_PI=4, NUM_PO=1).
// When a pattern is issued, the stimulus pushes the hand-computed result and
// its expected arrival cycle into a scoreboard queue. A monitor pops an entry
// from the queue whenever res_valid is seen and compares it. The stimulus
// process also checks the per-cycle CUT controls at the falling edge.
// -----------------------------------------------------------------------------
module tb_loc_scan_ctrl;

    localparam int CL = 3;
    localparam int PI = 4;
    localparam int PO = 1;

    logic          CLK = 1'b0;
    logic          RSTN;
    logic          pat_valid;
    logic          pat_ready;
    logic [CL-1:0] pat_scan;
    logic [PI-1:0] pat_v1;
    logic [PI-1:0] pat_v2;
    logic [CL-1:0] pat_exp_so;
    logic [PO-1:0] pat_exp_po;
    logic          cut_se;
    logic          cut_ce;
    logic          cut_si;
    logic [PI-1:0] cut_pi;
    logic          cut_so;
    logic [PO-1:0] cut_po;
    logic          res_valid;
    logic          res_fail;
    logic [CL-1:0] res_so;
    logic          busy;

    loc_scan_ctrl #(.CHAIN_LEN(CL), .NUM_PI(PI), .NUM_PO(PO)) dut (
        .CLK        (CLK),
        .RSTN       (RSTN),
        .pat_valid  (pat_valid),
        .pat_ready  (pat_ready),
        .pat_scan   (pat_scan),
        .pat_v1     (pat_v1),
        .pat_v2     (pat_v2),
        .pat_exp_so (pat_exp_so),
        .pat_exp_po (pat_exp_po),
        .cut_se     (cut_se),
        .cut_ce     (cut_ce),
        .cut_si     (cut_si),
        .cut_pi     (cut_pi),
        .cut_so     (cut_so),
        .cut_po     (cut_po),
        .res_valid  (res_valid),
        .res_fail   (res_fail),
        .res_so     (res_so),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    int unsigned cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // One directed vector: pattern fields, the CUT response the bench drives,
    // and the hand-computed result.
    typedef struct {
        logic [CL-1:0] scan;
        logic [PI-1:0] v1;
        logic [PI-1:0] v2;
        logic [CL-1:0] exp_so;
        logic          exp_po;
        logic [CL-1:0] drv_so;
        logic          drv_po;
        logic          want_fail;
        logic [CL-1:0] want_so;
    } vec_t;

    typedef struct {
        logic          fail;
        logic [CL-1:0] so;
        int unsigned   at;
    } exp_t;

    vec_t vecs[7];
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor
    always @(negedge CLK) begin
        if (RSTN === 1'b1 && res_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_res: res_valid=1 with no result pending (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("res_fail", res_fail, e.fail);
                check("res_so", res_so, e.so);
                check("res_cycle", cyc, e.at);
            end
        end
    end

    task automatic reset_checks(input string tag);
        check({tag, "_se"}, cut_se, 0);
        check({tag, "_ce"}, cut_ce, 0);
        check({tag, "_si"}, cut_si, 0);
        check({tag, "_pi"}, cut_pi, 0);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_res_fail"}, res_fail, 0);
        check({tag, "_res_so"}, res_so, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_ready"}, pat_ready, 1);
    endtask

    // Issue n patterns back to back, starting at vecs[first]. The bench is at
    // the start of relative cycle 0, and the DUT is IDLE. Pattern j is offered
    // at cycle 6j. Its CAPTURE is at 6j+6, its unload at 6j+7..6j+9, and its
    // result at 6j+10. When abort_at >= 0, reset is pulsed at that cycle and
    // released one cycle later. Pending results are then dropped.
    task automatic run_seq(input int first, input int n, input int abort_at);
        int unsigned a;
        int          last_c;
        a      = cyc;
        last_c = (abort_at >= 0) ? abort_at + 1 : 6 * n + 5;
        for (int c = 0; c <= last_c; c++) begin
            int   ph;
            int   j;
            vec_t v;
            ph = c % 6;
            j  = c / 6;

            pat_valid  = 1'b0;
            pat_scan   = '1;
            pat_v1     = '1;
            pat_v2     = '1;
            pat_exp_so = '1;
            pat_exp_po = '1;
            cut_so     = 1'b0;
            cut_po     = '0;
            if (ph == 0 && j < n) begin
                v          = vecs[first + j];
                pat_valid  = 1'b1;
                pat_scan   = v.scan;
                pat_v1     = v.v1;
                pat_v2     = v.v2;
                pat_exp_so = v.exp_so;
                pat_exp_po = v.exp_po;
                sb.push_back('{fail: v.want_fail, so: v.want_so, at: a + c + 10});
            end
            if (ph == 0 && c > 0 && j <= n) cut_po = vecs[first + j - 1].drv_po;
            if (c >= 7 && (c - 7) % 6 < 3 && (c - 7) / 6 < n)
                cut_so = vecs[first + (c - 7) / 6].drv_so[(c - 7) % 6];
            if (abort_at >= 0 && c == abort_at)     RSTN = 1'b0;
            if (abort_at >= 0 && c == abort_at + 1) RSTN = 1'b1;

            @(negedge CLK);
            if (abort_at >= 0 && c == abort_at) begin
                reset_checks("midrst");
                sb.delete();
            end else if (abort_at < 0 || c < abort_at) begin
                if (ph >= 1 && ph <= 3) begin
                    check("shift_se", cut_se, 1);
                    check("shift_ce", cut_ce, 1);
                    check("shift_ready", pat_ready, 0);
                    if (j < n) begin
                        check("shift_si", cut_si, vecs[first + j].scan[ph - 1]);
                        check("shift_pi", cut_pi, vecs[first + j].v1);
                    end else begin
                        check("unload_si", cut_si, 0);
                    end
                end else if (ph == 4) begin
                    if (j < n) begin
                        check("gap_se", cut_se, 0);
                        check("gap_ce", cut_ce, 0);
                        check("gap_busy", busy, 1);
                    end else begin
                        check("idle_busy", busy, 0);
                        check("idle_ready", pat_ready, 1);
                        check("idle_se", cut_se, 0);
                    end
                end else if (ph == 5) begin
                    if (j < n) begin
                        check("launch_se", cut_se, 0);
                        check("launch_ce", cut_ce, 1);
                        check("launch_pi", cut_pi, vecs[first + j].v1);
                    end else begin
                        check("after_busy", busy, 0);
                        check("after_res_valid", res_valid, 0);
                    end
                end else if (c == 0) begin
                    check("start_ready", pat_ready, 1);
                    check("start_busy", busy, 0);
                end else begin
                    check("capture_se", cut_se, 0);
                    check("capture_ce", cut_ce, 1);
                    check("capture_pi", cut_pi, vecs[first + j - 1].v2);
                    check("capture_ready", pat_ready, 1);
                end
            end
            @(posedge CLK);
            #1;
        end
        pat_valid = 1'b0;
        if (abort_at < 0) check("sb_drained", sb.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // scan v1 v2 exp_so exp_po drv_so drv_po want_fail want_so
        vecs[0] = '{3'b101, 4'b0000, 4'b0001, 3'b011, 1'b1, 3'b011, 1'b1, 1'b0, 3'b011};
        vecs[1] = '{3'b010, 4'b0011, 4'b1100, 3'b110, 1'b0, 3'b110, 1'b0, 1'b0, 3'b110};
        vecs[2] = '{3'b110, 4'b1010, 4'b0101, 3'b011, 1'b1, 3'b001, 1'b1, 1'b1, 3'b001}; // SO mismatch
        vecs[3] = '{3'b011, 4'b0110, 4'b1001, 3'b011, 1'b1, 3'b011, 1'b0, 1'b1, 3'b011}; // PO mismatch only
        vecs[4] = '{3'b001, 4'b1111, 4'b0000, 3'b100, 1'b0, 3'b100, 1'b0, 1'b0, 3'b100};
        vecs[5] = '{3'b111, 4'b0101, 4'b1010, 3'b101, 1'b1, 3'b101, 1'b1, 1'b0, 3'b101};
        vecs[6] = '{3'b100, 4'b1001, 4'b0110, 3'b000, 1'b0, 3'b100, 1'b0, 1'b1, 3'b100}; // last-bit mismatch

        RSTN       = 1'b0;
        pat_valid  = 1'b0;
        pat_scan   = '0;
        pat_v1     = '0;
        pat_v2     = '0;
        pat_exp_so = '0;
        pat_exp_po = '0;
        cut_so     = 1'b0;
        cut_po     = '0;
        @(negedge CLK);
        reset_checks("rst");
        @(posedge CLK);
        #1;
        RSTN = 1'b1;
        @(posedge CLK);
        #1;

        run_seq(0, 1, -1);   // isolated pattern
        run_seq(0, 2, -1);   // back-to-back, accepted in CAPTURE
        run_seq(2, 2, -1);   // SO mismatch then PO-only mismatch, overlapped
        run_seq(4, 1, -1);
        run_seq(6, 1, -1);   // mismatch on the final unload bit
        run_seq(5, 1, 8);    // reset mid-unload; the result is discarded
        run_seq(5, 1, -1);   // restart directly after reset

        repeat (3) @(posedge CLK);
        #1;
        check("sb_final_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
